// File: rtl/hazard_tracker.sv
// Source side of the pipeline hazard interface: D/E/M/W tag and control pipeline,
// forwarding/load-use match flags, qualified write enables and stall/flush counters.
module hazard_tracker #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSD,
  input  logic             CondExE,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  output logic             Match_1E_M,
  output logic             Match_1E_W,
  output logic             Match_2E_M,
  output logic             Match_2E_W,
  output logic             Match_12D_E,
  output logic             MemtoRegE,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             PCSrcW,
  output logic             PCWrPendingF,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             validd;
  logic [REG_W-1:0] ra1e, ra2e, wa3e;
  logic             regwritee, pcse;
  logic [REG_W-1:0] wa3m, wa3w;
  logic             pcsm;

  logic regwrite_dq, memtoreg_dq, pcs_dq;

  // D-stage control only counts while the decoder holds a live instruction
  assign regwrite_dq = RegWriteD & validd;
  assign memtoreg_dq = MemtoRegD & validd;
  assign pcs_dq      = PCSD & validd;

  // D-stage valid: flush kills, stall holds, otherwise a fresh instruction arrives
  always_ff @(posedge clk) begin
    if (!reset) begin
      validd <= 1'b0;
    end else if (FlushD) begin
      validd <= 1'b0;
    end else if (!StallD) begin
      validd <= 1'b1;
    end
  end

  // D->E register; a stall alone does not hold E, the hazard unit pairs it with FlushE
  always_ff @(posedge clk) begin
    if (!reset || FlushE) begin
      ra1e      <= '0;
      ra2e      <= '0;
      wa3e      <= '0;
      regwritee <= 1'b0;
      MemtoRegE <= 1'b0;
      pcse      <= 1'b0;
    end else begin
      ra1e      <= RA1D;
      ra2e      <= RA2D;
      wa3e      <= WA3D;
      regwritee <= regwrite_dq;
      MemtoRegE <= memtoreg_dq;
      pcse      <= pcs_dq;
    end
  end

  // E->M and M->W advance every cycle; the condition check gates writes leaving E
  always_ff @(posedge clk) begin
    if (!reset) begin
      wa3m      <= '0;
      RegWriteM <= 1'b0;
      pcsm      <= 1'b0;
      wa3w      <= '0;
      RegWriteW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      wa3m      <= wa3e;
      RegWriteM <= regwritee & CondExE;
      pcsm      <= pcse & CondExE;
      wa3w      <= wa3m;
      RegWriteW <= RegWriteM;
      PCSrcW    <= pcsm;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if ((FlushD || FlushE) && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Raw tag equalities; the hazard unit qualifies them with the write enables
  assign Match_1E_M   = (ra1e == wa3m);
  assign Match_1E_W   = (ra1e == wa3w);
  assign Match_2E_M   = (ra2e == wa3m);
  assign Match_2E_W   = (ra2e == wa3w);
  assign Match_12D_E  = validd & ((RA1D == wa3e) | (RA2D == wa3e));
  assign PCWrPendingF = pcs_dq | pcse | pcsm;

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed table, hand-written corner
// sequences and randomized traffic against an instruction-level pipeline model.
module tb_hazard_tracker;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [REG_W-1:0] ra1d, ra2d, wa3d;
  logic             regwrited, memtoregd, pcsd, condexe, stalld, flushd, flushe;
  logic             m1em, m1ew, m2em, m2ew, m12de, memtorege;
  logic             regwritem, regwritew, pcsrcw, pcwrpend;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [9:0]       flags;

  hazard_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(ra1d), .RA2D(ra2d), .WA3D(wa3d),
    .RegWriteD(regwrited), .MemtoRegD(memtoregd), .PCSD(pcsd),
    .CondExE(condexe), .StallD(stalld), .FlushD(flushd), .FlushE(flushe),
    .Match_1E_M(m1em), .Match_1E_W(m1ew), .Match_2E_M(m2em), .Match_2E_W(m2ew),
    .Match_12D_E(m12de), .MemtoRegE(memtorege), .RegWriteM(regwritem),
    .RegWriteW(regwritew), .PCSrcW(pcsrcw), .PCWrPendingF(pcwrpend),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign flags = {m1em, m1ew, m2em, m2ew, m12de, memtorege,
                  regwritem, regwritew, pcsrcw, pcwrpend};

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Instruction-level model: one record per in-flight instruction in E, M, W
  typedef struct packed {
    logic [REG_W-1:0] ra1, ra2, wa3;
    logic             rw, mr, pcs;
  } instr_t;

  bit     mdl_valid;
  instr_t mdl_pipe [3];   // 0=E, 1=M, 2=W
  int     mdl_stall, mdl_flush;

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  function automatic logic [9:0] exp_flags();
    instr_t e, m, w;
    e = mdl_pipe[0]; m = mdl_pipe[1]; w = mdl_pipe[2];
    return {e.ra1 == m.wa3, e.ra1 == w.wa3, e.ra2 == m.wa3, e.ra2 == w.wa3,
            mdl_valid && (ra1d == e.wa3 || ra2d == e.wa3),
            e.mr, m.rw, w.rw, w.pcs,
            (pcsd && mdl_valid) || e.pcs || m.pcs};
  endfunction

  task automatic model_advance();
    instr_t d, leaving_e;
    if (!reset) begin
      mdl_valid = 0;
      foreach (mdl_pipe[i]) mdl_pipe[i] = '0;
      mdl_stall = 0;
      mdl_flush = 0;
    end else begin
      d = '{ra1: ra1d, ra2: ra2d, wa3: wa3d, rw: regwrited && mdl_valid,
             mr: memtoregd && mdl_valid, pcs: pcsd && mdl_valid};
      leaving_e     = mdl_pipe[0];
      leaving_e.rw  = leaving_e.rw && condexe;
      leaving_e.pcs = leaving_e.pcs && condexe;
      mdl_pipe[2] = mdl_pipe[1];
      mdl_pipe[1] = leaving_e;
      mdl_pipe[0] = flushe ? '0 : d;
      if (stalld) mdl_stall = sat_inc(mdl_stall);
      if (flushd || flushe) mdl_flush = sat_inc(mdl_flush);
      if (flushd) mdl_valid = 0;
      else if (!stalld) mdl_valid = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic drive(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                       input logic rw, input logic mr, input logic pcs, input logic cond,
                       input logic st, input logic fd, input logic fe);
    ra1d = a1; ra2d = a2; wa3d = w; regwrited = rw; memtoregd = mr; pcsd = pcs;
    condexe = cond; stalld = st; flushd = fd; flushe = fe;
    #1;
  endtask

  task automatic nop(input logic cond);
    drive(4'd1, 4'd1, 4'd0, 0, 0, 0, cond, 0, 0, 0);
  endtask

  task automatic drive_random();
    drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 3) == 0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) begin
      drive_random();
      tick();
    end
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] ra1, ra2, wa3;
    logic       rw, mr, pcs, cond;
    logic [9:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                              input logic rw, input logic mr, input logic pcs,
                              input logic cond, input logic [9:0] exp);
    vec_t v;
    v.ra1 = a1; v.ra2 = a2; v.wa3 = w; v.rw = rw; v.mr = mr; v.pcs = pcs;
    v.cond = cond; v.exp = exp;
    return v;
  endfunction

  vec_t tbl [5];

  initial begin
    // flags: {1E_M,1E_W,2E_M,2E_W,12D_E,MemtoRegE,RegWriteM,RegWriteW,PCSrcW,PCWrPending}
    tbl[0] = mk(4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 10'b1111000000);
    tbl[1] = mk(4'd1, 4'd2, 4'd3, 1, 0, 0, 1, 10'b1111000000);
    tbl[2] = mk(4'd3, 4'd4, 4'd6, 0, 0, 0, 1, 10'b0000100000);
    tbl[3] = mk(4'd3, 4'd0, 4'd0, 0, 0, 0, 1, 10'b1000001000);
    tbl[4] = mk(4'd1, 4'd1, 4'd0, 0, 0, 0, 1, 10'b0100000100);

    reset = 1'b0;
    nop(1);
    do_reset();

    // Reset state under random decode inputs
    drive_random();
    chk("reset_flags", 32'(flags), 32'b1111000000);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);

    // Forward path
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].wa3, tbl[i].rw, tbl[i].mr, tbl[i].pcs,
            tbl[i].cond, 0, 0, 0);
      chk($sformatf("fwd_row%0d", i), 32'(flags), 32'(tbl[i].exp));
      chk($sformatf("fwd_row%0d_cnt", i), {16'(stall_cnt), 16'(flush_cnt)}, 0);
      tick();
    end

    // Load-use: bubble into E while the decoder is held
    do_reset();
    nop(1); tick();
    drive(4'd1, 4'd2, 4'd5, 1, 1, 0, 1, 0, 0, 0); tick();
    drive(4'd7, 4'd5, 4'd8, 1, 0, 0, 1, 1, 0, 1);
    chk("lu_match12de", 32'(m12de), 1);
    chk("lu_memtorege", 32'(memtorege), 1);
    tick();
    drive(4'd7, 4'd5, 4'd8, 1, 0, 0, 1, 0, 0, 0);
    chk("lu_bubble_memtorege", 32'(memtorege), 0);
    chk("lu_bubble_match12de", 32'(m12de), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_flush_cnt", 32'(flush_cnt), 1);
    tick();
    nop(1);
    chk("lu_reissue_memtorege", 32'(memtorege), 0);
    tick();

    // Condition fail squashes the register and PC writes
    do_reset();
    nop(1); tick();
    drive(4'd1, 4'd2, 4'd9, 1, 0, 1, 1, 0, 0, 0);
    chk("cf_pending_d", 32'(pcwrpend), 1);
    tick();
    nop(0);
    chk("cf_pending_e", 32'(pcwrpend), 1);
    tick();
    nop(1);
    chk("cf_regwritem", 32'(regwritem), 0);
    chk("cf_pending_m", 32'(pcwrpend), 0);
    tick();
    nop(1);
    chk("cf_pcsrcw", 32'(pcsrcw), 0);
    chk("cf_regwritew", 32'(regwritew), 0);
    tick();

    // FlushD beats StallD
    do_reset();
    nop(1); tick();
    drive(4'd1, 4'd2, 4'd4, 1, 0, 0, 1, 1, 1, 0); tick();
    drive(4'd4, 4'd2, 4'd4, 1, 0, 1, 1, 0, 0, 0);
    chk("fp_match12de", 32'(m12de), 0);
    chk("fp_pending", 32'(pcwrpend), 0);
    chk("fp_flush_cnt", 32'(flush_cnt), 1);
    tick();
    chk("fp_revalid_match12de", 32'(m12de), 1);
    chk("fp_revalid_pending", 32'(pcwrpend), 1);
    tick();

    // Reset mid-operation leaks no write
    do_reset();
    nop(1); tick();
    drive(4'd1, 4'd2, 4'd2, 1, 0, 0, 1, 0, 0, 0); tick();
    nop(1); tick();
    chk("rm_regwritem_before", 32'(regwritem), 1);
    reset = 1'b0; tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rm_regwrite_after%0d", i), {31'(regwritem), regwritew}, 0);
      tick();
    end

    // Counter saturation
    do_reset();
    drive(4'd1, 4'd1, 4'd0, 0, 0, 0, 1, 1, 0, 0);
    repeat (14) tick();
    chk("sat_stall14", 32'(stall_cnt), 14);
    tick();
    chk("sat_stall15", 32'(stall_cnt), 15);
    repeat (4) tick();
    chk("sat_stall_hold", 32'(stall_cnt), 15);
    chk("sat_flush_zero", 32'(flush_cnt), 0);
    drive(4'd1, 4'd1, 4'd0, 0, 0, 0, 1, 1, 1, 1);
    repeat (18) tick();
    chk("sat_both", {16'(stall_cnt), 16'(flush_cnt)}, {16'd15, 16'd15});

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      drive_random();
      chk("rnd_flags", 32'(flags), 32'(exp_flags()));
      chk("rnd_stall_cnt", 32'(stall_cnt), 32'(mdl_stall));
      chk("rnd_flush_cnt", 32'(flush_cnt), 32'(mdl_flush));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
Source side of the pipeline hazard interface. Owns the D/E/M/W register-tag and control-bit pipeline and produces the match, pending and qualified write-enable signals that the hazard unit consumes. It also applies the stall/flush commands returned by the hazard unit to its own tag pipeline. Includes saturating stall/flush event counters for performance debug.

Parameters:
REG_W, 4, register-address width (r0..r15)
CNT_W, 16, width of stall/flush event counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-low reset
RA1D  in  REG_W  decode source register 1
RA2D  in  REG_W  decode source register 2
WA3D  in  REG_W  decode destination register
RegWriteD  in  1  decode instruction writes register file
MemtoRegD  in  1  decode instruction is a load
PCSD  in  1  decode instruction writes PC
CondExE  in  1  condition check passed for the E-stage instruction
StallD  in  1  hold D stage (from hazard unit)
FlushD  in  1  kill D-stage instruction (from hazard unit)
FlushE  in  1  insert bubble into E (from hazard unit)
Match_1E_M  out  1  RA1E == WA3M
Match_1E_W  out  1  RA1E == WA3W
Match_2E_M  out  1  RA2E == WA3M
Match_2E_W  out  1  RA2E == WA3W
Match_12D_E  out  1  (RA1D == WA3E) or (RA2D == WA3E), qualified by ValidD
MemtoRegE  out  1  E-stage instruction is a load
RegWriteM  out  1  qualified register write in M
RegWriteW  out  1  qualified register write in W
PCSrcW  out  1  qualified PC write in W
PCWrPendingF  out  1  PC write in flight in D, E or M
stall_cnt  out  CNT_W  cycles with StallD=1
flush_cnt  out  CNT_W  cycles with FlushD=1 or FlushE=1

Behaviour:
- All state updates on rising clk; reset=0 at an edge clears every flop.
- Reset values: ValidD=0; all E/M/W tags and control bits 0; counters 0. All outputs are therefore 0 immediately after reset, except the Match_*E_* equality flags, which read 1 because all tags are 0.
- ValidD flop:
  - Priority order: reset, then FlushD (ValidD<=0), then StallD (hold), else ValidD<=1.
  - FlushD beats StallD when both are asserted.
- D-stage control is qualified: RegWriteD, MemtoRegD and PCSD are each ANDed with ValidD before use.
- D->E register: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSE.
  - FlushE=1: all fields cleared to 0 (bubble).
  - Otherwise: load from D.
  - StallD alone does not hold E. The hazard unit pairs StallD with FlushE on a load-use hazard.
- E->M register, unconditional:
  - WA3M<=WA3E
  - RegWriteM<=RegWriteE & CondExE
  - PCSM<=PCSE & CondExE
- M->W register, unconditional: WA3W<=WA3M, RegWriteW<=RegWriteM, PCSrcW<=PCSM.
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W: combinational equality of the registered tags. They are not qualified by RegWrite; the hazard unit qualifies them.
- Match_12D_E: combinational, uses the current RA1D/RA2D against WA3E, ANDed with ValidD.
- PCWrPendingF: combinational, (PCSD & ValidD) | PCSE | PCSM.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones (no wrap). Both counters may increment in the same cycle.
- Load-use sequence:
  - Cycle N: Match_12D_E=1 with MemtoRegE=1.
  - Edge N+1: E becomes a bubble; the D tags are re-presented because the decoder is held.
  - Cycle N+1: Match_12D_E is recomputed against the bubble (WA3E=0). stall_cnt has incremented.
- Reset asserted mid-operation clears in-flight writes; no RegWriteW pulse leaks after reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> RegWriteM/W, PCSrcW, PCWrPendingF, MemtoRegE, counters all 0; ValidD=0.
- Forward path: issue WA3D=3, RegWriteD=1, then next instruction RA1D=3; CondExE=1 -> one cycle later Match_1E_M=1 & RegWriteM=1; the following cycle Match_1E_W=1 & RegWriteW=1.
- Load-use: load WA3D=5, MemtoRegD=1, then RA2D=5 -> Match_12D_E=1 & MemtoRegE=1. Drive StallD=FlushE=1 for 1 cycle -> E fields 0 next cycle, stall_cnt=1, flush_cnt=1.
- Condition fail: RegWriteD=1, PCSD=1 with CondExE=0 in E -> RegWriteM=0, PCSrcW=0. PCWrPendingF is 1 while in D and E, then 0 once in M.
- Flush priority: StallD=1 and FlushD=1 together -> ValidD=0 next cycle; Match_12D_E=0 and PCWrPendingF ignores PCSD.
- Saturation: preload counters by holding StallD=1 for 2^CNT_W+3 cycles (CNT_W=4 build) -> stall_cnt stays at 15, no wrap.
